// File: rtl/gearbox_down_axis.sv
// gearbox_down_axis: wide-to-narrow AXI-Stream width converter.
// Holds one IN_W word and emits it as R = IN_W/OUT_W registered beats.
// Trailing all-zero-keep beats of a TLAST word are trimmed.
module gearbox_down_axis #(
    parameter int IN_W      = 128,
    parameter int OUT_W     = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_W-1:0]      s_data,
    input  logic [IN_W/8-1:0]    s_keep,
    input  logic                 s_last,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [OUT_W-1:0]     m_data,
    output logic [OUT_W/8-1:0]   m_keep,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready
);

    localparam int R   = IN_W / OUT_W;
    localparam int KW  = IN_W / 8;
    localparam int OKW = OUT_W / 8;
    localparam int CW  = (R > 2) ? $clog2(R) : 1;

    if ((IN_W % OUT_W) != 0 || (OUT_W % 8) != 0 || R < 2) begin : g_param_check
        $fatal(1, "gearbox_down_axis: IN_W must be a multiple of OUT_W, OUT_W a multiple of 8, ratio >= 2");
    end

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IN_W-1:0]   word_p0;
    logic [KW-1:0]     keep_p0;
    logic              last_p0;
    logic [CW-1:0]     cnt_p0;
    logic [CW-1:0]     fin_p0;
    logic [CW-1:0]     cnt_nx;
    logic [CW-1:0]     fin_new;
    logic              beat_done;
    logic              load;
    logic              adv;

    // Beat n of a data word, in the selected word order.
    function automatic logic [OUT_W-1:0] data_slice(input logic [IN_W-1:0] w,
                                                    input logic [CW-1:0]   n);
        if (MSB_FIRST)
            data_slice = w[IN_W-1-int'(n)*OUT_W -: OUT_W];
        else
            data_slice = w[int'(n)*OUT_W +: OUT_W];
    endfunction

    // Byte-enable slice that travels with beat n.
    function automatic logic [OKW-1:0] keep_slice(input logic [KW-1:0] k,
                                                  input logic [CW-1:0] n);
        if (MSB_FIRST)
            keep_slice = k[KW-1-int'(n)*OKW -: OKW];
        else
            keep_slice = k[int'(n)*OKW +: OKW];
    endfunction

    // Index of the last beat to emit: all beats for a non-final word,
    // otherwise the last beat carrying any enabled byte (0 if none do).
    function automatic logic [CW-1:0] final_beat(input logic [KW-1:0] k,
                                                 input logic          last);
        logic [CW-1:0] f;
        f = last ? '0 : CW'(R - 1);
        if (last) begin
            for (int i = 0; i < R; i++) begin
                if (keep_slice(k, CW'(i)) != '0) f = CW'(i);
            end
        end
        return f;
    endfunction

    assign beat_done = (cnt_p0 == fin_p0);
    assign cnt_nx    = cnt_p0 + 1'b1;
    assign fin_new   = final_beat(s_keep, s_last);
    assign m_valid   = (state_q == SHIFT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: leave SHIFT only when the final beat drains with no word waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_valid) state_d = SHIFT;
            SHIFT:   if (m_ready && beat_done && !s_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake decode: accept a new word when empty or as the final beat leaves.
    always_comb begin
        s_ready = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE:  s_ready = 1'b1;
            SHIFT: begin
                s_ready = m_ready && beat_done;
                adv     = m_ready && !beat_done;
            end
            default: s_ready = 1'b0;
        endcase
        load = s_valid && s_ready;
    end

    // Holding register and registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_p0 <= '0;
            keep_p0 <= '0;
            last_p0 <= 1'b0;
            cnt_p0  <= '0;
            fin_p0  <= '0;
            m_data  <= '0;
            m_keep  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            word_p0 <= s_data;
            keep_p0 <= s_keep;
            last_p0 <= s_last;
            cnt_p0  <= '0;
            fin_p0  <= fin_new;
            m_data  <= data_slice(s_data, '0);
            m_keep  <= keep_slice(s_keep, '0);
            m_last  <= s_last && (fin_new == '0);
        end else if (adv) begin
            cnt_p0  <= cnt_nx;
            m_data  <= data_slice(word_p0, cnt_nx);
            m_keep  <= keep_slice(keep_p0, cnt_nx);
            m_last  <= last_p0 && (cnt_nx == fin_p0);
        end
    end

endmodule

// File: tb/tb_gearbox_down_axis.sv
// Testbench for gearbox_down_axis: vector table on the default instance,
// plus streaming, reset, word-order and 64->8 instances.
module tb_gearbox_down_axis;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default instance (128 -> 32, MSB first)
    logic [127:0] s_data = '0;
    logic [15:0]  s_keep = '0;
    logic         s_last = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  m_data;
    logic [3:0]   m_keep;
    logic         m_last;
    logic         m_valid;
    logic         m_ready = 1'b0;

    // LSB-first instance shares s_data/s_keep/s_last
    logic         s_valid_b = 1'b0;
    logic         s_ready_b;
    logic [31:0]  m_data_b;
    logic [3:0]   m_keep_b;
    logic         m_last_b;
    logic         m_valid_b;
    logic         m_ready_b = 1'b0;

    // 64 -> 8 instance
    logic [63:0]  c_s_data = '0;
    logic [7:0]   c_s_keep = '0;
    logic         c_s_last = 1'b0;
    logic         c_s_valid = 1'b0;
    logic         c_s_ready;
    logic [7:0]   c_m_data;
    logic [0:0]   c_m_keep;
    logic         c_m_last;
    logic         c_m_valid;
    logic         c_m_ready = 1'b0;

    gearbox_down_axis #(.IN_W(128), .OUT_W(32), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
    );

    gearbox_down_axis #(.IN_W(128), .OUT_W(32), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_valid(s_valid_b), .s_ready(s_ready_b),
        .m_data(m_data_b), .m_keep(m_keep_b), .m_last(m_last_b), .m_valid(m_valid_b), .m_ready(m_ready_b)
    );

    gearbox_down_axis #(.IN_W(64), .OUT_W(8), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .s_data(c_s_data), .s_keep(c_s_keep), .s_last(c_s_last), .s_valid(c_s_valid), .s_ready(c_s_ready),
        .m_data(c_m_data), .m_keep(c_m_keep), .m_last(c_m_last), .m_valid(c_m_valid), .m_ready(c_m_ready)
    );

    typedef struct {
        string           name;
        logic [127:0]    data;
        logic [15:0]     keep;
        logic            last;
        int              nb;
        logic [3:0][31:0] ed;   // expected beat b in ed[b]
        logic [3:0][3:0]  ek;   // expected keep b in ek[b]
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] E0 = 128'hCCDDEEFF_8899AABB_44556677_00112233;
    localparam logic [127:0] D6 = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3;
    localparam logic [127:0] E6 = 128'hF0E1D2C3_89ABCDEF_01234567_DEADBEEF;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t         vecs[8];
    logic [127:0] wd[100];
    logic [15:0]  wk[100];
    logic         wl[100];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply one table vector with m_ready high and check every beat.
    task automatic run_vec(input vec_t v);
        int t;
        @(posedge clk); #1;
        s_data = v.data; s_keep = v.keep; s_last = v.last; s_valid = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({v.name, " accept"}, s_ready, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        for (int b = 0; b < v.nb; b++) begin
            @(negedge clk);
            chk($sformatf("%s b%0d valid", v.name, b), m_valid, 1'b1);
            chk($sformatf("%s b%0d data", v.name, b), m_data, v.ed[b]);
            chk($sformatf("%s b%0d keep", v.name, b), m_keep, v.ek[b]);
            chk($sformatf("%s b%0d last", v.name, b), m_last, v.last && (b == v.nb - 1));
            chk($sformatf("%s b%0d s_ready", v.name, b), s_ready, b == v.nb - 1);
        end
        @(negedge clk);
        chk({v.name, " no extra beat"}, m_valid, 1'b0);
    endtask

    // Expected beats of one word (MSB-first, 32-bit beats, trailing trim).
    task automatic push_word(input logic [127:0] d, input logic [15:0] k, input logic l,
                             inout beat_t q[$]);
        int f;
        beat_t bt;
        f = 3;
        if (l) begin
            f = 0;
            for (int n = 0; n < 4; n++) if (k[15-4*n -: 4] != 4'h0) f = n;
        end
        for (int n = 0; n <= f; n++) begin
            bt.d = d[127-32*n -: 32];
            bt.k = k[15-4*n -: 4];
            bt.l = l && (n == f);
            q.push_back(bt);
        end
    endtask

    // Stream nw words from wd/wk/wl; m_ready random when rnd, else held high.
    task automatic run_stream(input string tag, input int nw, input bit rnd,
                              output int mv_cycles, output int span, output int srdy_cnt);
        beat_t q[$];
        beat_t e;
        int    widx = 0;
        int    cyc = 0;
        int    first = -1;
        int    lastc = -1;
        bit    acc;
        bit    prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic [3:0]  pk = '0;
        logic        pl = 1'b0;
        mv_cycles = 0;
        srdy_cnt  = 0;
        @(posedge clk); #1;
        s_data = wd[0]; s_keep = wk[0]; s_last = wl[0]; s_valid = 1'b1;
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        while (cyc < 5000 && (widx < nw || q.size() != 0)) begin
            if (m_valid) begin
                mv_cycles++;
                if (first < 0) first = cyc;
                lastc = cyc;
                if (s_ready) srdy_cnt++;
                if (prev_stall) begin
                    chk($sformatf("%s hold data c%0d", tag, cyc), m_data, pd);
                    chk($sformatf("%s hold keep c%0d", tag, cyc), m_keep, pk);
                    chk($sformatf("%s hold last c%0d", tag, cyc), m_last, pl);
                end
                if (m_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("%s unexpected beat c%0d", tag, cyc), 1'b1, 1'b0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("%s data c%0d", tag, cyc), m_data, e.d);
                        chk($sformatf("%s keep c%0d", tag, cyc), m_keep, e.k);
                        chk($sformatf("%s last c%0d", tag, cyc), m_last, e.l);
                    end
                end
            end else if (prev_stall) begin
                chk($sformatf("%s valid dropped c%0d", tag, cyc), m_valid, 1'b1);
            end
            prev_stall = m_valid && !m_ready;
            pd = m_data; pk = m_keep; pl = m_last;
            acc = s_valid && s_ready;
            if (acc) push_word(wd[widx], wk[widx], wl[widx], q);
            @(posedge clk); #1;
            if (acc) begin
                widx++;
                if (widx < nw) begin
                    s_data = wd[widx]; s_keep = wk[widx]; s_last = wl[widx];
                end else begin
                    s_valid = 1'b0;
                end
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " words accepted"}, widx, nw);
        chk({tag, " beats drained"}, q.size(), 0);
        span = (first < 0) ? 0 : lastc - first + 1;
        s_valid = 1'b0;
        m_ready = 1'b1;
    endtask

    // LSB-first instance: one word, full-keep beats expected.
    task automatic run_b(input string tag, input logic [127:0] d, input logic [15:0] k,
                         input int nb, input logic [3:0][31:0] ed);
        @(posedge clk); #1;
        s_data = d; s_keep = k; s_last = 1'b1; s_valid_b = 1'b1; m_ready_b = 1'b1;
        @(negedge clk);
        chk({tag, " accept"}, s_ready_b, 1'b1);
        @(posedge clk); #1;
        s_valid_b = 1'b0;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            chk($sformatf("%s b%0d valid", tag, b), m_valid_b, 1'b1);
            chk($sformatf("%s b%0d data", tag, b), m_data_b, ed[b]);
            chk($sformatf("%s b%0d keep", tag, b), m_keep_b, 4'hF);
            chk($sformatf("%s b%0d last", tag, b), m_last_b, b == nb - 1);
        end
        @(negedge clk);
        chk({tag, " no extra beat"}, m_valid_b, 1'b0);
    endtask

    initial begin
        int mvc, spn, src;

        vecs[0] = '{"full",     D0, 16'hFFFF, 1'b1, 4, E0, 16'hFFFF};
        vecs[1] = '{"nolast",   D0, 16'hFFFF, 1'b0, 4, E0, 16'hFFFF};
        vecs[2] = '{"trimFF00", D0, 16'hFF00, 1'b1, 2, E0, 16'h00FF};
        vecs[3] = '{"trim0",    D0, 16'h0000, 1'b1, 1, E0, 16'h0000};
        vecs[4] = '{"keep0nl",  D0, 16'h0000, 1'b0, 4, E0, 16'h0000};
        vecs[5] = '{"holes",    D0, 16'h0F0F, 1'b1, 4, E0, 16'hF0F0};
        vecs[6] = '{"partial",  D6, 16'hFFF8, 1'b1, 4, E6, 16'h8FFF};
        vecs[7] = '{"trimF000", D6, 16'hF000, 1'b1, 1, E6, 16'h000F};

        // Reset state
        #1;
        chk("reset m_valid", m_valid, 1'b0);
        chk("reset m_data", m_data, 32'h0);
        chk("reset m_keep", m_keep, 4'h0);
        chk("reset m_last", m_last, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset s_ready", s_ready, 1'b1);
        chk("post-reset m_valid", m_valid, 1'b0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back: three words, no bubbles
        for (int i = 0; i < 3; i++) begin
            wd[i] = {4{32'h1000_0000 + 32'(i)}} ^ D6;
            wk[i] = 16'hFFFF;
            wl[i] = (i == 2);
        end
        run_stream("b2b", 3, 1'b0, mvc, spn, src);
        chk("b2b valid cycles", mvc, 12);
        chk("b2b span", spn, 12);
        chk("b2b s_ready pulses", src, 3);

        // Random backpressure over 100 words
        for (int i = 0; i < 100; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom};
            wl[i] = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       wk[i] = 16'h0000;
                1:       wk[i] = 16'hFFFF;
                default: wk[i] = 16'($urandom);
            endcase
        end
        run_stream("bp", 100, 1'b1, mvc, spn, src);

        // Reset in the middle of a packet
        @(posedge clk); #1;
        s_data = D0; s_keep = 16'hFFFF; s_last = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        chk("mid-rst accept", s_ready, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-rst beat2 data", m_data, 32'h8899AABB);
        rst_n = 1'b0;
        #1;
        chk("mid-rst m_valid", m_valid, 1'b0);
        chk("mid-rst m_last", m_last, 1'b0);
        chk("mid-rst m_data", m_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after-rst s_ready", s_ready, 1'b1);
        chk("after-rst m_valid", m_valid, 1'b0);
        run_vec(vecs[0]);

        // LSB-first word order
        run_b("lsb full", D0, 16'hFFFF, 4, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        run_b("lsb trim", D0, 16'h00FF, 2, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // 64 -> 8 instance
        @(posedge clk); #1;
        c_s_data = 64'h0102030405060708; c_s_keep = 8'hFF; c_s_last = 1'b1;
        c_s_valid = 1'b1; c_m_ready = 1'b1;
        @(negedge clk);
        chk("w8 accept", c_s_ready, 1'b1);
        @(posedge clk); #1;
        c_s_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            chk($sformatf("w8 b%0d valid", b), c_m_valid, 1'b1);
            chk($sformatf("w8 b%0d data", b), c_m_data, 8'(b + 1));
            chk($sformatf("w8 b%0d keep", b), c_m_keep, 1'b1);
            chk($sformatf("w8 b%0d last", b), c_m_last, b == 7);
        end
        @(negedge clk);
        chk("w8 no extra beat", c_m_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
